// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and helpers for the seven-segment scan driver
package ssd_pkg;

  localparam logic [6:0] CHAR_DASH = 7'h40;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  function automatic int ticks_per_digit(input int clk_hz, input int frame_hz, input int n_digits);
    return clk_hz / (frame_hz * n_digits);
  endfunction

endpackage

// File: rtl/ssd_lz_mask.sv
// rtl/ssd_lz_mask.sv - leading-zero suppression mask, MSD downward
// Digit 0 is never masked so an all-zero value still shows a single 0.
module ssd_lz_mask #(
  parameter int N_DIGITS = 4
) (
  input  logic [4*N_DIGITS-1:0] num,
  output logic [N_DIGITS-1:0]   mask
);

  logic run;

  always_comb begin
    mask = '0;
    run  = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      run     = run & (num[4*k +: 4] == 4'd0);
      mask[k] = run;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multiplexed N-digit seven-segment driver with frame-synchronous load
// Define SSD_DIM_EN to build the PWM brightness sub-phase logic.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int FRAME_HZ   = 400,
  parameter int DIM_BITS   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_num,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_blank,
  input  logic                  i_lz_en,
  input  logic [DIM_BITS-1:0]   i_bright,
  output logic                  o_ack,
  output logic [N_DIGITS-1:0]   o_digit_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp
);

  localparam int TICKS = ticks_per_digit(CLK_HZ, FRAME_HZ, N_DIGITS);
  localparam int CNT_W = $clog2(TICKS);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICKS - 1);
  localparam logic [IDX_W-1:0]    IDX_MSD  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{(ACTIVE_LOW != 0)}};
  localparam logic [6:0]          SEG_OFF  = {7{(ACTIVE_LOW != 0)}};
  localparam logic                DP_OFF   = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] disp_num, pend_num;
  logic [N_DIGITS-1:0]   disp_dp, pend_dp, disp_blank, pend_blank;
  logic                  pend_valid;
  logic                  slot_end, frame_end, commit;
  logic                  lit;
  logic [N_DIGITS-1:0]   lz_mask;

  assign slot_end  = (slot_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == '0);
  assign commit    = frame_end && (pend_valid || i_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= IDX_MSD;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        idx <= (idx == '0) ? IDX_MSD : idx - 1'b1;
    end
  end

  // A load landing on the commit cycle bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_num   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      disp_num   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      o_ack      <= 1'b0;
    end else begin
      if (i_load) begin
        pend_num   <= i_num;
        pend_dp    <= i_dp;
        pend_blank <= i_blank;
      end
      if (frame_end)
        pend_valid <= 1'b0;
      else if (i_load)
        pend_valid <= 1'b1;
      if (commit) begin
        disp_num   <= i_load ? i_num   : pend_num;
        disp_dp    <= i_load ? i_dp    : pend_dp;
        disp_blank <= i_load ? i_blank : pend_blank;
      end
      o_ack <= commit;
    end
  end

`ifdef SSD_DIM_EN
  localparam int SUB_LEN = TICKS >> DIM_BITS;
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_LEN - 1);

  logic [SUB_W-1:0]    sub_cnt;
  logic [DIM_BITS-1:0] phase;

  // The phase saturates at its maximum, so remainder cycles stay in the last sub-phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt <= '0;
      phase   <= '0;
    end else if (slot_end) begin
      sub_cnt <= '0;
      phase   <= '0;
    end else if (sub_cnt == SUB_LAST) begin
      sub_cnt <= '0;
      if (phase != '1)
        phase <= phase + 1'b1;
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

  assign lit = (phase <= i_bright);
`else
  logic unused_bright;
  assign unused_bright = ^i_bright;
  assign lit = 1'b1;
`endif

  ssd_lz_mask #(.N_DIGITS(N_DIGITS)) u_lz_mask (
    .num  (disp_num),
    .mask (lz_mask)
  );

  logic [3:0]          nib;
  logic                dark;
  logic [6:0]          seg_hi;
  logic                dp_hi;
  logic [N_DIGITS-1:0] an_hi;

  // Slot cycle 0 keeps every anode off so the previous digit cannot ghost.
  always_comb begin
    nib    = disp_num[4*idx +: 4];
    dark   = disp_blank[idx] | (i_lz_en & lz_mask[idx]);
    seg_hi = dark ? 7'h00 : hex_to_seg(nib);
    dp_hi  = ~dark & disp_dp[idx];
    an_hi  = ((slot_cnt != '0) && lit) ? (N_DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_digit_en <= AN_OFF;
      o_seg      <= SEG_OFF;
      o_dp       <= DP_OFF;
    end else begin
      o_digit_en <= an_hi ^ AN_OFF;
      o_seg      <= seg_hi ^ SEG_OFF;
      o_dp       <= dp_hi ^ DP_OFF;
    end
  end

endmodule
